// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage RV32I pipeline control path:
// PC-source, result-select, forwarding selects and the hazard FSM state.
package pipe_pkg;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] RES_LOAD  = 2'b01;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_W     = 2'b01;
  localparam logic [1:0] FWD_M     = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
    logic abort_f;
  } hz_ctrl_t;

  // The M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
    else                                         return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational E-stage operand forwarding for both ALU source operands.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E
);

  assign ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
  assign ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: prioritised stall/flush controls, wait-tracking
// FSM with a sticky watchdog, and stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic [1:0]       PCSrc_E,
  input  logic             dmem_valid_M,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic             Abort_F,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic dwait, redirect, lwstall, iwait;
  hz_ctrl_t ctrl;

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  forward_unit u_fwd (
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .Rd_M       (Rd_M),
    .Rd_W       (Rd_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E)
  );

  assign dwait    = dmem_valid_M && !dmem_ready;
  assign redirect = PCSrc_E != PC_PLUS4;
  assign lwstall  = (ResultSrc_E == RES_LOAD) && (Rd_E != 5'd0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign iwait    = !imem_ready;

  // Controls are forced low while reset is asserted so the pipeline stays quiet.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ctrl = '0;
    if (rst_n) begin
      if (dwait) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
        ctrl.flush_w = 1'b1;
      end else if (redirect) begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
        ctrl.abort_f = iwait;
      end else if (lwstall) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end else if (iwait) begin
        ctrl.stall_f = 1'b1;
        ctrl.flush_d = 1'b1;
      end
    end
  end

  assign Stall_F = ctrl.stall_f;
  assign Stall_D = ctrl.stall_d;
  assign Stall_E = ctrl.stall_e;
  assign Stall_M = ctrl.stall_m;
  assign Flush_D = ctrl.flush_d;
  assign Flush_E = ctrl.flush_e;
  assign Flush_W = ctrl.flush_w;
  assign Abort_F = ctrl.abort_f;

  always_comb begin
    state_d = RUN;
    if (dwait)                    state_d = DWAIT;
    else if (iwait && !redirect)  state_d = IWAIT;

    // Leaving RUN always starts a fresh streak at one.
    wait_cnt_d = '0;
    if (state_d != RUN) begin
      if (state_q == RUN)                          wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != WAIT_W'(TIMEOUT))     wait_cnt_d = wait_cnt_q + 1'b1;
      else                                         wait_cnt_d = wait_cnt_q;
    end

    mem_timeout_d = mem_timeout_q ||
                    ((state_d != RUN) && (wait_cnt_q == WAIT_W'(TIMEOUT - 1)));
    stall_cnt_d   = stall_cnt_q + CNT_W'(ctrl.stall_f);
    flush_cnt_d   = flush_cnt_q + CNT_W'(redirect && !dwait);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
